anycore_l15_req_arbiter: RTL

//  Parametrised request front-end between the AnyCore L1 miss/store ports and the L1.5 transducer request interface.

---
 rtl/anycore_l15_req_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/anycore_l15_req_arbiter.sv
// AnyCore L1 -> L1.5 request front-end. Instruction-miss and load requests
// each occupy a one-entry pending slot, and stores are queued in a FIFO.
// One request at a time is arbitrated onto the L1.5 interface and held
// there until l15_transducer_ack.
module anycore_l15_req_arbiter #(
  parameter int PHY_ADDR_W = 40,
  parameter int IC_BLK_W   = 34,
  parameter int DC_BLK_W   = 34,
  parameter int ST_ADDR_W  = 37,
  parameter int STQ_DEPTH  = 4,
  parameter int ARB_MODE   = 0,
  parameter int SWAP_BYTES = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IC_BLK_W-1:0]              ic_reqaddr,
  input  logic                             ic_reqvalid,
  output logic                             ic_reqready,
  input  logic [DC_BLK_W-1:0]              dc_ldaddr,
  input  logic                             dc_ldvalid,
  output logic                             dc_ldready,
  input  logic [ST_ADDR_W-1:0]             dc_staddr,
  input  logic [63:0]                      dc_stdata,
  input  logic [2:0]                       dc_stsize,
  input  logic                             dc_stvalid,
  output logic                             dc_stready,
  input  logic                             l15_transducer_ack,
  output logic                             l15_val,
  output logic [4:0]                       l15_rqtype,
  output logic [2:0]                       l15_size,
  output logic [PHY_ADDR_W-1:0]            l15_address,
  output logic [63:0]                      l15_data,
  output logic                             l15_nc,
  output logic [$clog2(STQ_DEPTH+1)-1:0]   stq_count
);

  localparam int PTR_W = $clog2(STQ_DEPTH);
  localparam int CNT_W = $clog2(STQ_DEPTH+1);

  localparam logic [4:0] IMISS_RQ  = 5'b10000;
  localparam logic [4:0] LOAD_RQ   = 5'b00000;
  localparam logic [4:0] STORE_RQ  = 5'b00001;
  localparam logic [2:0] PCX_SZ_4B = 3'b010;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  typedef enum logic [1:0] {G_IMISS, G_LOAD, G_STORE} grant_t;

  state_t               state, state_nxt;
  grant_t               grant_q, grant_sel;
  logic                 issue;
  logic                 ack_fire;
  logic                 rr_imiss;
  logic                 ic_pend, ld_pend;
  logic [IC_BLK_W-1:0]  ic_addr_q;
  logic [DC_BLK_W-1:0]  ld_addr_q;
  logic [ST_ADDR_W-1:0] stq_addr [STQ_DEPTH];
  logic [63:0]          stq_data [STQ_DEPTH];
  logic [2:0]           stq_size [STQ_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 st_push, st_pop, stq_nonempty, data_cand;
  logic [63:0]          ic_byte_addr, ld_byte_addr, st_byte_addr;

  function automatic logic [63:0] swap64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
    return r;
  endfunction

  assign ic_reqready  = ~ic_pend;
  assign dc_ldready   = ~ld_pend;
  assign dc_stready   = (stq_count < CNT_W'(STQ_DEPTH));
  assign l15_nc       = l15_address[PHY_ADDR_W-1];
  assign stq_nonempty = (stq_count != '0);
  assign data_cand    = stq_nonempty | ld_pend;
  assign ack_fire     = (state == S_ISSUE) && l15_transducer_ack;
  assign st_push      = dc_stvalid && dc_stready;
  assign st_pop       = ack_fire && (grant_q == G_STORE);

  // Byte addresses of each candidate: imiss zero-extended, load and store sign-extended.
  always_comb begin
    ic_byte_addr = {{(64-IC_BLK_W-6){1'b0}}, ic_addr_q, 6'b0};
    ld_byte_addr = {{(64-DC_BLK_W-6){ld_addr_q[DC_BLK_W-1]}}, ld_addr_q, 6'b0};
    st_byte_addr = {{(64-ST_ADDR_W-3){stq_addr[rd_ptr][ST_ADDR_W-1]}}, stq_addr[rd_ptr], 3'b0};
  end

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and grant selection; a queued store always shadows the pending load.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    grant_sel = G_IMISS;
    case (state)
      S_IDLE: begin
        if (ic_pend || data_cand) begin
          issue     = 1'b1;
          state_nxt = S_ISSUE;
          if (ic_pend && (!data_cand || (ARB_MODE == 0) || rr_imiss)) grant_sel = G_IMISS;
          else if (stq_nonempty)                                      grant_sel = G_STORE;
          else                                                        grant_sel = G_LOAD;
        end
      end
      S_ISSUE: if (l15_transducer_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pending slots for imiss and load: filled on handshake, released on their ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ic_pend   <= 1'b0;
      ld_pend   <= 1'b0;
      ic_addr_q <= '0;
      ld_addr_q <= '0;
    end else begin
      if (ic_reqvalid && !ic_pend) begin
        ic_pend   <= 1'b1;
        ic_addr_q <= ic_reqaddr;
      end else if (ack_fire && (grant_q == G_IMISS)) begin
        ic_pend <= 1'b0;
      end
      if (dc_ldvalid && !ld_pend) begin
        ld_pend   <= 1'b1;
        ld_addr_q <= dc_ldaddr;
      end else if (ack_fire && (grant_q == G_LOAD)) begin
        ld_pend <= 1'b0;
      end
    end
  end

  // Store FIFO payload storage.
  always_ff @(posedge clk) begin
    if (st_push) begin
      stq_addr[wr_ptr] <= dc_staddr;
      stq_data[wr_ptr] <= dc_stdata;
      stq_size[wr_ptr] <= dc_stsize;
    end
  end

  // Store FIFO pointers and occupancy; the in-flight head stays counted until its ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      stq_count <= '0;
    end else begin
      if (st_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (st_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({st_push, st_pop})
        2'b10:   stq_count <= stq_count + CNT_W'(1);
        2'b01:   stq_count <= stq_count - CNT_W'(1);
        default: stq_count <= stq_count;
      endcase
    end
  end

  // L1.5 output registers: loaded on grant, held until ack, and valid dropped after ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l15_val     <= 1'b0;
      l15_rqtype  <= '0;
      l15_size    <= '0;
      l15_address <= '0;
      l15_data    <= '0;
      grant_q     <= G_IMISS;
      rr_imiss    <= 1'b1;
    end else if (issue) begin
      l15_val  <= 1'b1;
      grant_q  <= grant_sel;
      rr_imiss <= (grant_sel != G_IMISS);
      case (grant_sel)
        G_IMISS: begin
          l15_rqtype  <= IMISS_RQ;
          l15_size    <= PCX_SZ_4B;
          l15_address <= PHY_ADDR_W'(ic_byte_addr);
          l15_data    <= '0;
        end
        G_LOAD: begin
          l15_rqtype  <= LOAD_RQ;
          l15_size    <= PCX_SZ_4B;
          l15_address <= PHY_ADDR_W'(ld_byte_addr);
          l15_data    <= '0;
        end
        default: begin
          l15_rqtype  <= STORE_RQ;
          l15_size    <= stq_size[rd_ptr];
          l15_address <= PHY_ADDR_W'(st_byte_addr);
          l15_data    <= (SWAP_BYTES != 0) ? swap64(stq_data[rd_ptr]) : stq_data[rd_ptr];
        end
      endcase
    end else if (ack_fire) begin
      l15_val <= 1'b0;
    end
  end

endmodule
